// File: rtl/conv_pool.sv
// Streaming 4x4-tile convolution engine: three signed 3x3 kernels, 2x2 max-pool,
// ReLU, shift and saturate, one tile per clock through a 4-cycle read-to-write pipeline.
`default_nettype none

module conv_pool #(
    parameter logic [15:0] LAST_ADDR = 16'hFFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] image_4x4,
    input  logic [71:0]  conv_kernel_0,
    input  logic [71:0]  conv_kernel_1,
    input  logic [71:0]  conv_kernel_2,
    input  logic [1:0]   shift,
    output logic         input_re,
    output logic [15:0]  input_addr,
    output logic         output_we_0,
    output logic         output_we_1,
    output logic         output_we_2,
    output logic [15:0]  output_addr_0,
    output logic [15:0]  output_addr_1,
    output logic [15:0]  output_addr_2,
    output logic [7:0]   y_0,
    output logic [7:0]   y_1,
    output logic [7:0]   y_2
);

    typedef enum logic {S_RUN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_addr;
    logic [15:0]         w_addr_nxt;
    logic                w_re;

    logic [71:0]         w_kern [3];
    logic signed [20:0]  w_sum  [3][4];
    logic [19:0]         w_pool [3];
    logic [19:0]         w_scaled [3];
    logic [7:0]          w_sat  [3];

    logic                r_v0, r_v1, r_v2, r_v3;
    logic [15:0]         r_a0, r_a1, r_a2, r_a3;
    logic signed [20:0]  r_s1 [3][4];
    logic [19:0]         r_s2 [3];
    logic [7:0]          r_y3 [3];

    // Signed sum of nine unsigned-pixel x signed-weight products for output (a,b).
    function automatic logic signed [20:0] f_conv(
        input logic [127:0] tile,
        input logic [71:0]  kern,
        input int           a,
        input int           b
    );
        logic signed [20:0] acc;
        logic signed [16:0] prod;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                prod = $signed({1'b0, tile[8*(4*(a+i)+b+j) +: 8]}) * $signed(kern[8*(3*i+j) +: 8]);
                acc  = acc + 21'(prod);
            end
        end
        return acc;
    endfunction

    function automatic logic [19:0] f_pool_relu(
        input logic signed [20:0] c0,
        input logic signed [20:0] c1,
        input logic signed [20:0] c2,
        input logic signed [20:0] c3
    );
        logic signed [20:0] m;
        logic [19:0]        res;
        m = c0;
        if (c1 > m) m = c1;
        if (c2 > m) m = c2;
        if (c3 > m) m = c3;
        res = (m < 0) ? 20'd0 : m[19:0];
        return res;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_re        = 1'b0;
        case (r_state)
            S_RUN: begin
                w_re = 1'b1;
                if (r_addr == LAST_ADDR) w_state_nxt = S_DONE;
                else                     w_addr_nxt  = r_addr + 16'd1;
            end
            S_DONE: w_re = 1'b0;
            default: w_state_nxt = S_DONE;
        endcase
    end

    assign w_kern[0] = conv_kernel_0;
    assign w_kern[1] = conv_kernel_1;
    assign w_kern[2] = conv_kernel_2;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            for (int q = 0; q < 4; q++) begin
                w_sum[k][q] = f_conv(image_4x4, w_kern[k], q / 2, q % 2);
            end
            w_pool[k]   = f_pool_relu(r_s1[k][0], r_s1[k][1], r_s1[k][2], r_s1[k][3]);
            w_scaled[k] = r_s2[k] >> shift;
            w_sat[k]    = (|w_scaled[k][19:8]) ? 8'hFF : w_scaled[k][7:0];
        end
    end

    // Valid bits and the visible output register are cleared; in-flight tiles die on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_a3 <= '0;
            for (int k = 0; k < 3; k++) r_y3[k] <= '0;
        end else begin
            r_v0 <= w_re;
            r_v1 <= r_v0;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_a3 <= r_a2;
            for (int k = 0; k < 3; k++) r_y3[k] <= w_sat[k];
        end
    end

    // NOTE: datapath stage registers carry no reset; their contents are ignored until the valid bit says otherwise.
    always_ff @(posedge clk) begin
        r_a0 <= r_addr;
        r_a1 <= r_a0;
        r_a2 <= r_a1;
        for (int k = 0; k < 3; k++) begin
            for (int q = 0; q < 4; q++) r_s1[k][q] <= w_sum[k][q];
            r_s2[k] <= w_pool[k];
        end
    end

    // Outputs are forced idle for as long as reset is held, so no write escapes after it asserts.
    assign input_re      = rst & w_re;
    assign input_addr    = rst ? r_addr : 16'd0;
    assign output_we_0   = rst & r_v3;
    assign output_we_1   = rst & r_v3;
    assign output_we_2   = rst & r_v3;
    assign output_addr_0 = rst ? r_a3 : 16'd0;
    assign output_addr_1 = rst ? r_a3 : 16'd0;
    assign output_addr_2 = rst ? r_a3 : 16'd0;
    assign y_0           = rst ? r_y3[0] : 8'd0;
    assign y_1           = rst ? r_y3[1] : 8'd0;
    assign y_2           = rst ? r_y3[2] : 8'd0;

endmodule

`default_nettype wire

// File: tb/tb_conv_pool.sv
// Bench for conv_pool: tile memory responder, integer golden model, per-cycle compare
// of reads and writes, and whole-result-memory checks after each directed run.
`timescale 1ns/1ps

module tb_conv_pool;

    localparam logic [15:0] LAST = 16'd63;
    localparam int          N    = 64;

    logic         clk;
    logic         rst;
    logic [127:0] image_4x4;
    logic [71:0]  kern [3];
    logic [1:0]   shift;
    logic         input_re;
    logic [15:0]  input_addr;
    logic         output_we_0, output_we_1, output_we_2;
    logic [15:0]  output_addr_0, output_addr_1, output_addr_2;
    logic [7:0]   y_0, y_1, y_2;

    conv_pool #(.LAST_ADDR(LAST)) dut (
        .clk           (clk),
        .rst           (rst),
        .image_4x4     (image_4x4),
        .conv_kernel_0 (kern[0]),
        .conv_kernel_1 (kern[1]),
        .conv_kernel_2 (kern[2]),
        .shift         (shift),
        .input_re      (input_re),
        .input_addr    (input_addr),
        .output_we_0   (output_we_0),
        .output_we_1   (output_we_1),
        .output_we_2   (output_we_2),
        .output_addr_0 (output_addr_0),
        .output_addr_1 (output_addr_1),
        .output_addr_2 (output_addr_2),
        .y_0           (y_0),
        .y_1           (y_1),
        .y_2           (y_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] tile_mem [N];

    // Registered read port: address in cycle n, tile visible in cycle n+1.
    always @(posedge clk) begin
        if (input_re) image_4x4 <= tile_mem[input_addr[5:0]];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec-level model: plain integer convolution, max, clamp, shift, saturate.
    function automatic int golden(input logic [127:0] t, input logic [71:0] k, input logic [1:0] sh);
        int best;
        int c;
        best = 0;
        for (int q = 0; q < 4; q++) begin
            c = 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    c += int'(t[8*(4*(q/2+i)+(q%2+j)) +: 8]) * int'($signed(k[8*(3*i+j) +: 8]));
            if (q == 0 || c > best) best = c;
        end
        if (best < 0) best = 0;
        best = best >> sh;
        return (best > 255) ? 255 : best;
    endfunction

    typedef struct {
        int addr;
        int due;
    } pend_t;

    pend_t pq[$];
    int    cyc      = 0;
    int    exp_rd   = 0;
    int    n_writes = 0;
    int    res_mem [3][N];

    logic       we_k   [3];
    logic [15:0] addr_k [3];
    logic [7:0]  y_k    [3];
    assign we_k[0] = output_we_0;  assign we_k[1] = output_we_1;  assign we_k[2] = output_we_2;
    assign addr_k[0] = output_addr_0; assign addr_k[1] = output_addr_1; assign addr_k[2] = output_addr_2;
    assign y_k[0] = y_0;  assign y_k[1] = y_1;  assign y_k[2] = y_2;

    // Single compare process: reset values, read sequence, write timing, address and data.
    always @(negedge clk) begin
        int  a;
        bit  exp_we;
        cyc++;
        if (!rst) begin
            check("rst_enables", {input_re, output_we_0, output_we_1, output_we_2}, 0);
            check("rst_addrs", int'(input_addr | output_addr_0 | output_addr_1 | output_addr_2), 0);
            check("rst_data", {y_0, y_1, y_2}, 0);
            pq.delete();
            exp_rd   = 0;
            n_writes = 0;
        end else begin
            exp_we = (pq.size() > 0) && (pq[0].due == cyc);
            for (int k = 0; k < 3; k++) check($sformatf("we_%0d", k), we_k[k], exp_we);
            if (exp_we) begin
                a = pq[0].addr;
                void'(pq.pop_front());
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("waddr_%0d", k), addr_k[k], a);
                    check($sformatf("y_%0d@%0d", k, a), y_k[k], golden(tile_mem[a], kern[k], shift));
                    res_mem[k][a] = y_k[k];
                end
                n_writes++;
            end
            if (input_re) begin
                check("rd_addr", input_addr, exp_rd);
                pq.push_back('{exp_rd % N, cyc + 4});
                exp_rd++;
            end
        end
    end

    function automatic logic [71:0] kfill(input logic [7:0] v);
        return {9{v}};
    endfunction

    function automatic logic [71:0] kcenter();
        logic [71:0] k;
        k = '0;
        k[39:32] = 8'd1;
        return k;
    endfunction

    task automatic fill_const(input logic [7:0] v);
        for (int a = 0; a < N; a++) tile_mem[a] = {16{v}};
    endtask

    task automatic fill_ramp();
        logic [7:0] v;
        for (int a = 0; a < N; a++) begin
            v = a[7:0];
            tile_mem[a] = {16{v}};
        end
    endtask

    task automatic do_run(input string tag, input logic [1:0] sh, input int mid_rst);
        bit done;
        bit hit;
        int bad;
        shift = sh;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < N; a++) res_mem[k][a] = -1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        if (mid_rst >= 0) begin
            hit = 1'b0;
            for (int t = 0; t < 4 * N && !hit; t++) begin
                @(negedge clk);
                if (input_re && input_addr == 16'(mid_rst)) hit = 1'b1;
            end
            check({tag, "_reach_mid"}, hit, 1);
            @(posedge clk); #1 rst = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
        end
        done = 1'b0;
        for (int t = 0; t < N + 60 && !done; t++) begin
            @(posedge clk);
            if (exp_rd >= N && pq.size() == 0) done = 1'b1;
        end
        check({tag, "_done"}, done, 1);
        repeat (6) @(negedge clk);
        check({tag, "_nwrites"}, n_writes, N);
        check({tag, "_re_idle"}, input_re, 0);
        bad = 0;
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < N; a++)
                if (res_mem[k][a] != golden(tile_mem[a], kern[k], sh)) bad++;
        check({tag, "_mem_bad"}, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        image_4x4 = '0;
        shift     = 2'd0;
        kern[0]   = '0;
        kern[1]   = '0;
        kern[2]   = '0;

        // Basic: ones kernel, center kernel with a hand-built tile 5, all -1 kernel.
        fill_const(8'd1);
        tile_mem[5][47:40] = 8'd10;
        tile_mem[5][55:48] = 8'd200;
        tile_mem[5][79:72] = 8'd30;
        tile_mem[5][87:80] = 8'd40;
        kern[0] = kfill(8'd1);
        kern[1] = kcenter();
        kern[2] = kfill(8'hFF);
        do_run("basic", 2'd0, -1);
        check("lit_ones_sum9", res_mem[0][0], 9);
        check("lit_center_a5", res_mem[1][5], 200);
        check("lit_center_a4", res_mem[1][4], 1);
        check("lit_neg_clamp", res_mem[2][3], 0);

        // Saturation and negative clamp at the extremes.
        fill_const(8'd255);
        kern[0] = kfill(8'd127);
        kern[1] = kfill(8'h80);
        kern[2] = kfill(8'h00);
        do_run("sat_s0", 2'd0, -1);
        check("lit_sat_s0", res_mem[0][10], 255);
        check("lit_min_kern", res_mem[1][10], 0);
        check("lit_zero_kern", res_mem[2][10], 0);
        do_run("sat_s3", 2'd3, -1);
        check("lit_sat_s3", res_mem[0][11], 255);

        // Shift: sum 144 for kernel 0, 16 for center, 288 for the all-2 kernel.
        fill_const(8'd16);
        kern[0] = kfill(8'd1);
        kern[1] = kcenter();
        kern[2] = kfill(8'd2);
        do_run("shift0", 2'd0, -1);
        check("lit_shift0", res_mem[0][7], 144);
        check("lit_shift0_288", res_mem[2][7], 255);
        do_run("shift2", 2'd2, -1);
        check("lit_shift2", res_mem[0][7], 36);
        check("lit_shift2_288", res_mem[2][7], 72);
        do_run("shift3", 2'd3, -1);
        check("lit_shift3", res_mem[0][7], 18);
        check("lit_shift3_ctr", res_mem[1][7], 2);

        // Streaming ramp: each tile carries its own address as pixel value.
        fill_ramp();
        kern[0] = kcenter();
        kern[1] = kfill(8'd1);
        kern[2] = kfill(8'hFF);
        do_run("stream", 2'd0, -1);
        check("lit_ramp_a37", res_mem[0][37], 37);
        check("lit_ramp_9x20", res_mem[1][20], 180);
        check("lit_ramp_9x29", res_mem[1][29], 255);

        // Reset in the middle of the stream, then a full clean restart.
        do_run("midrst", 2'd0, 40);
        check("lit_midrst_a63", res_mem[0][63], 63);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_pool.md
# conv_pool

Streaming convolution + max-pool engine. Each input word is a 4x4 tile of unsigned 8-bit pixels. The block applies three independent signed 3x3 kernels to the tile, giving a 2x2 valid convolution per kernel. It then 2x2 max-pools, applies ReLU, scales and saturates, and writes one 8-bit result per tile per kernel to three result memories. It masters a 1-cycle-latency image read port and three write ports, and sustains one tile per clock.

## Interface
Parameters:
- LAST_ADDR, 16'hFFFF, last tile address processed; the run covers tiles 0..LAST_ADDR.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- image_4x4  in  128  tile from image memory; pixel p[r][c] = bits [8*(4r+c)+7 : 8*(4r+c)], r,c in 0..3, unsigned.
- conv_kernel_0/1/2  in  72 each  kernel weights; w[i][j] = bits [8*(3i+j)+7 : 8*(3i+j)], i,j in 0..2, signed two's complement; static during a run.
- shift  in  2  right-shift amount 0..3 applied before saturation; static during a run.
- input_re  out  1  image read enable.
- input_addr  out  16  image read address.
- output_we_0/1/2  out  1 each  result write enable, one per kernel.
- output_addr_0/1/2  out  16 each  result write address.
- y_0/1/2  out  8 each  result data.

## Operation
- After rst releases, issue reads for addresses 0,1,…,LAST_ADDR on consecutive cycles with input_re=1.
- After the last address, hold input_re=0 and stay in DONE until the next reset; no wrap-around.
- The read port is registered. Address A presented in cycle n yields image_4x4 = tile A in cycle n+1.
- Convolution for each kernel k and each output position (a,b), a,b in 0..1:
  - c[a][b] = Σ_{i,j} p[a+i][b+j] * w[i][j].
  - Each product is unsigned 8 × signed 8, held as 17-bit signed.
  - Each sum is held as 21-bit signed, with no overflow possible.
- Pool: m = max of c[0][0], c[0][1], c[1][0], c[1][1], using signed compare.
- ReLU: if m < 0 then m = 0.
- Scale: s = m >> shift (logical, since the value is non-negative).
- Saturate: y = 255 if s > 255, else s[7:0].
- All three kernels operate in lockstep on the same tile. Output addresses are identical across kernels and equal the tile address.

## Timing
- Pipeline stages for a read issued in cycle n (address A):
  - Cycle n+1: tile present; S1 register captures the 4 convolution sums per kernel at the end of n+1.
  - S2 register captures the pooled, ReLU'd value at the end of n+2.
  - S3 output register captures shift/saturate at the end of n+3.
  - In cycle n+4: output_we_k=1, output_addr_k=A, y_k valid; the write is taken at the rising edge ending cycle n+4.
- Latency from address issue to write-enable is 4 cycles.
- Throughput is 1 tile/cycle with no bubbles. For a full run, output_we is high for exactly LAST_ADDR+1 consecutive cycles, starting 4 cycles after the first input_re.
- A valid bit travels with each stage; output_we is the S3 valid bit.
- Reset values while rst=0 and in the first cycle after: input_re=0, input_addr=0, output_we_k=0, output_addr_k=0, y_k=0.
- All pipeline valid bits are cleared and the address counter is zeroed during reset.
- First read: input_re=1, input_addr=0 in the first cycle with rst=1 after reset.
- Reset mid-run:
  - In-flight tiles are discarded, with no write after reset asserts.
  - After release, the run restarts from address 0.
- shift and the kernels are sampled combinationally at their stage; changes during a run affect only tiles not yet past that stage.

## Test plan
- All pixels 1, kernel_0 all 1, shift 0: y_0=9 for every address. Kernel_1 center 1, rest 0, with the tile at address 5 having p[1][1]=10, p[1][2]=200, p[2][1]=30, p[2][2]=40: y_1=200 at output_addr_1=5.
- Negative clamp: kernel_2 all -1 (8'hFF), any nonzero tile: y_2=0. Kernel all 0: y=0.
- Saturation: all pixels 255, kernel all 127, shift 0: sum 291465, y=255. With shift 3: 36433, still y=255. Kernel all -128: y=0.
- Shift: all pixels 16, kernel all 1 (sum 144):
  - shift 0: y=144.
  - shift 2: y=36.
  - shift 3: y=18.
- Streaming and order, with tile A having all pixels = A[7:0] and kernel center 1:
  - y = A[7:0] at address A for all 65536 addresses.
  - First write exactly 4 cycles after the first input_re.
  - No gaps, and no write after address 65535.
- Reset mid-run: assert rst=0 at address ~1000 for 2 cycles. Required:
  - output_we=0 from the reset edge.
  - input_addr restarts at 0.
  - The final result memory matches golden for all addresses.
